// File: rtl/exttrg_seq_pkg.sv
// Shared definitions for the external-trigger sequencer: register map,
// CTRL/STATUS bit positions and the pulse FSM state encoding.
package exttrg_seq_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_WIDTH  = 3'd2;
  localparam logic [2:0] ADDR_PERIOD = 3'd3;
  localparam logic [2:0] ADDR_COUNT  = 3'd4;
  localparam logic [2:0] ADDR_SENT   = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_MANUAL = 3;
  localparam int CTRL_IRQ_EN = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/exttrg_phase_counter.sv
// Loadable down-counter timing one HIGH or LOW phase; stops at zero so it
// never wraps regardless of CNT_W.
module exttrg_phase_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/exttrg_sequencer.sv
// Avalon-MM programmable pulse-train generator driving the external trigger
// line. Valid/ready: a write is accepted on any clk edge where chipselect=1
// and write_n=0; reads are combinational with zero latency, no wait states.
module exttrg_sequencer
  import exttrg_seq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int DEF_WIDTH  = 1,
  parameter int DEF_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  seq_state_t       r_state, w_state_nxt;
  logic             r_cont, r_manual, r_irq_en, r_done, r_out;
  logic [CNT_W-1:0] r_width, r_period, r_count, r_sent;
  logic [CNT_W-1:0] r_n, r_w_m1, r_low_m1;

  logic             w_wr, w_wr_ctrl, w_start, w_stop, w_busy;
  logic             w_cont_nxt, w_manual_nxt, w_out_nxt;
  logic [CNT_W-1:0] w_eff_w, w_eff_w_m1, w_eff_low_m1, w_load_val;
  logic             w_load, w_zero, w_set_done, w_clr_done, w_start_go;
  logic             w_sent_clr, w_sent_inc, w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_ctrl = w_wr && (address == ADDR_CTRL);
  assign w_start   = w_wr_ctrl & writedata[CTRL_START];
  assign w_stop    = w_wr_ctrl & writedata[CTRL_STOP];
  assign w_busy    = (r_state != IDLE);
  assign w_unused_wdata = ^writedata;

  assign w_cont_nxt   = w_wr_ctrl ? writedata[CTRL_CONT]   : r_cont;
  assign w_manual_nxt = w_wr_ctrl ? writedata[CTRL_MANUAL] : r_manual;

  // p = max(PERIOD, w+1); the LOW phase lasts p-w cycles, so load p-w-1.
  assign w_eff_w      = (r_width == '0) ? CNT_W'(1) : r_width;
  assign w_eff_w_m1   = w_eff_w - CNT_W'(1);
  assign w_eff_low_m1 = (r_period > w_eff_w) ? (r_period - w_eff_w - CNT_W'(1)) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = r_w_m1;
    w_set_done  = 1'b0;
    w_clr_done  = 1'b0;
    w_start_go  = 1'b0;
    w_sent_clr  = 1'b0;
    w_sent_inc  = 1'b0;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_set_done  = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          w_sent_clr = 1'b1;
          if ((r_count == '0) && !w_cont_nxt) begin
            w_set_done = 1'b1;
          end else begin
            w_clr_done  = 1'b1;
            w_start_go  = 1'b1;
            w_state_nxt = HIGH;
            w_load      = 1'b1;
            w_load_val  = w_eff_w_m1;
            w_sent_inc  = 1'b1;
          end
        end
        HIGH: if (w_zero) begin
          if (!r_cont && (r_sent == r_n)) begin
            w_state_nxt = IDLE;
            w_set_done  = 1'b1;
          end else begin
            w_state_nxt = LOW;
            w_load      = 1'b1;
            w_load_val  = r_low_m1;
          end
        end
        LOW: if (w_zero) begin
          w_state_nxt = HIGH;
          w_load      = 1'b1;
          w_load_val  = r_w_m1;
          w_sent_inc  = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_out_nxt = (w_state_nxt == HIGH) || ((w_state_nxt == IDLE) && w_manual_nxt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_out    <= 1'b0;
      r_cont   <= 1'b0;
      r_manual <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_width  <= CNT_W'(DEF_WIDTH);
      r_period <= CNT_W'(DEF_PERIOD);
      r_count  <= CNT_W'(1);
      r_sent   <= '0;
      r_n      <= '0;
      r_w_m1   <= '0;
      r_low_m1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if (w_wr_ctrl) begin
        r_cont   <= writedata[CTRL_CONT];
        r_manual <= writedata[CTRL_MANUAL];
        r_irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (w_wr && (address == ADDR_WIDTH))  r_width  <= writedata[CNT_W-1:0];
      if (w_wr && (address == ADDR_PERIOD)) r_period <= writedata[CNT_W-1:0];
      if (w_wr && (address == ADDR_COUNT))  r_count  <= writedata[CNT_W-1:0];
      // A completion event in the same cycle outranks a software clear.
      if (w_set_done) begin
        r_done <= 1'b1;
      end else if (w_clr_done || (w_wr && (address == ADDR_STATUS) && writedata[STAT_DONE])) begin
        r_done <= 1'b0;
      end
      if (w_sent_clr) begin
        r_sent <= w_sent_inc ? CNT_W'(1) : '0;
      end else if (w_sent_inc && (r_sent != '1)) begin
        r_sent <= r_sent + CNT_W'(1);
      end
      if (w_start_go) begin
        r_n      <= r_count;
        r_w_m1   <= w_eff_w_m1;
        r_low_m1 <= w_eff_low_m1;
      end
    end
  end

  exttrg_phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_busy),
    .o_zero     (w_zero)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = 32'({r_irq_en, r_manual, r_cont, 2'b00});
      ADDR_STATUS: readdata = 32'({r_done, w_busy});
      ADDR_WIDTH:  readdata = 32'(r_width);
      ADDR_PERIOD: readdata = 32'(r_period);
      ADDR_COUNT:  readdata = 32'(r_count);
      ADDR_SENT:   readdata = 32'(r_sent);
      default:     readdata = '0;
    endcase
  end

  assign out_port = r_out;
  assign irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_exttrg_sequencer.sv
// Directed bench for exttrg_sequencer: register defaults, burst/clamp/continuous
// waveforms, shadowing and collisions, manual level and asynchronous reset.
module tb_exttrg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  exttrg_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: a write is sampled on the posedge inside bus_write
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic capture(input int n, output logic [63:0] cap);
    cap = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap[k] = out_port;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] cap, exp;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset defaults
    bus_read(3'd0, rd); check("rst_ctrl",   64'(rd), 64'd0);
    bus_read(3'd1, rd); check("rst_status", 64'(rd), 64'd0);
    bus_read(3'd2, rd); check("rst_width",  64'(rd), 64'd1);
    bus_read(3'd3, rd); check("rst_period", 64'(rd), 64'd1000);
    bus_read(3'd4, rd); check("rst_count",  64'(rd), 64'd1);
    bus_read(3'd5, rd); check("rst_sent",   64'(rd), 64'd0);
    check("rst_out", 64'(out_port), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, rd); check("undef_addr", 64'(rd), 64'd0);
    bus_read(3'd0, rd); check("undef_wr_ctrl", 64'(rd), 64'd0);

    // burst: w=3, p=10, n=4
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'd10);
    bus_write(3'd4, 32'd4);
    bus_write(3'd0, 32'h1);
    capture(45, cap);
    exp = '0;
    for (int k = 0; k < 45; k++) exp[k] = (k < 40) && ((k % 10) < 3);
    check("burst_wave", cap, exp);
    bus_read(3'd1, rd); check("burst_status", 64'(rd), 64'd2);
    bus_read(3'd5, rd); check("burst_sent",   64'(rd), 64'd4);
    check("burst_irq_off", 64'(irq), 64'd0);

    // clamping: w=max(0,1)=1, p=max(0,2)=2, n=2
    bus_write(3'd1, 32'h2);
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd4, 32'd2);
    bus_write(3'd0, 32'h1);
    capture(8, cap);
    check("clamp_wave", cap, 64'b0000_0101);
    bus_read(3'd5, rd); check("clamp_sent", 64'(rd), 64'd2);

    // COUNT=0 completes immediately without a pulse
    bus_write(3'd1, 32'h2);
    bus_read(3'd1, rd); check("w1c_done", 64'(rd), 64'd0);
    bus_write(3'd4, 32'd0);
    bus_write(3'd0, 32'h1);
    capture(5, cap);
    check("cnt0_wave", cap, 64'd0);
    bus_read(3'd1, rd); check("cnt0_status", 64'(rd), 64'd2);
    bus_read(3'd5, rd); check("cnt0_sent",   64'(rd), 64'd0);

    // continuous w=2, p=5 with IRQ_EN, stopped after 23 cycles
    bus_write(3'd2, 32'd2);
    bus_write(3'd3, 32'd5);
    bus_write(3'd0, 32'h15);
    capture(23, cap);
    exp = '0;
    for (int k = 0; k < 23; k++) exp[k] = (k % 5) < 2;
    check("cont_wave", cap, exp);
    bus_write(3'd0, 32'h12);
    @(negedge clk);
    check("stop_out", 64'(out_port), 64'd0);
    bus_read(3'd1, rd); check("stop_status", 64'(rd), 64'd2);
    bus_read(3'd5, rd); check("stop_sent",   64'(rd), 64'd5);
    check("stop_irq", 64'(irq), 64'd1);
    bus_write(3'd1, 32'h2);
    @(negedge clk);
    check("irq_clear", 64'(irq), 64'd0);

    // shadowed WIDTH write and ignored START mid-burst
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'd10);
    bus_write(3'd4, 32'd2);
    bus_write(3'd0, 32'h1);
    cap = '0;
    for (int k = 0; k < 25; k++) begin
      if (k == 4) bus_write(3'd2, 32'd7);
      if (k == 6) bus_write(3'd0, 32'h1);
      @(negedge clk);
      cap[k] = out_port;
    end
    exp = '0;
    for (int k = 0; k < 25; k++) exp[k] = (k < 20) && ((k % 10) < 3);
    check("shadow_wave", cap, exp);
    bus_read(3'd5, rd); check("shadow_sent",  64'(rd), 64'd2);
    bus_read(3'd2, rd); check("shadow_width", 64'(rd), 64'd7);

    // START together with STOP in IDLE: STOP wins, SENT frozen
    bus_write(3'd1, 32'h2);
    bus_write(3'd0, 32'h3);
    capture(4, cap);
    check("ss_wave", cap, 64'd0);
    bus_read(3'd1, rd); check("ss_status", 64'(rd), 64'd2);
    bus_read(3'd5, rd); check("ss_sent",   64'(rd), 64'd2);

    // manual level while IDLE
    bus_write(3'd0, 32'h8);
    @(negedge clk);
    check("manual_out", 64'(out_port), 64'd1);
    bus_read(3'd0, rd); check("manual_ctrl", 64'(rd), 64'd8);

    // reset in the middle of a HIGH phase
    bus_write(3'd2, 32'd5);
    bus_write(3'd4, 32'd1);
    bus_write(3'd0, 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_out", 64'(out_port), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_out", 64'(out_port), 64'd0);
    bus_read(3'd2, rd); check("rst2_width",  64'(rd), 64'd1);
    bus_read(3'd5, rd); check("rst2_sent",   64'(rd), 64'd0);
    bus_read(3'd0, rd); check("rst2_ctrl",   64'(rd), 64'd0);
    bus_read(3'd1, rd); check("rst2_status", 64'(rd), 64'd0);
    bus_read(3'd3, rd); check("rst2_period", 64'(rd), 64'd1000);
    reset_n = 1'b1;
    capture(4, cap);
    check("post_rst_wave", cap, 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
